// File: rtl/acis_pkg.sv
// Shared widths, FSM encodings and the FP64 multiply/add primitives used by the
// acis streaming node. Subnormals are flushed to zero on input and output.
package acis_pkg;

    localparam int phit_size     = 512;
    localparam int dwidth_double = 64;
    localparam int SIMD_degree   = phit_size / dwidth_double;
    localparam int dwidth_RFadd  = 8;
    localparam int sz_config     = 36;
    localparam int sz_state      = 48;
    localparam int NUM_PE        = 6;
    localparam int OUT_LATENCY   = 79;
    localparam int PE_W          = 3;
    localparam int TBL_DEPTH     = 2 ** dwidth_RFadd;

    typedef logic [dwidth_double-1:0] fp64_t;

    typedef enum logic [2:0] {
        LD_IDLE, LD_WAIT1, LD_WAIT2, LD_STATE, LD_CFG, LD_INB, LD_DONE
    } ld_state_e;

    typedef enum logic [1:0] {
        SS_WAIT_LOAD, SS_HOLD, SS_READY
    } ss_state_e;

    localparam fp64_t FP64_QNAN = 64'h7FF8_0000_0000_0000;

    function automatic fp64_t fp64_mul(input fp64_t a, input fp64_t b);
        logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic         g, st, rnd;
        logic [52:0]  m;
        logic [53:0]  mr;
        logic [105:0] p;
        int           e;
        fp64_t        res;
        s      = a[63] ^ b[63];
        a_nan  = (&a[62:52]) && (|a[51:0]);
        b_nan  = (&b[62:52]) && (|b[51:0]);
        a_inf  = (&a[62:52]) && !(|a[51:0]);
        b_inf  = (&b[62:52]) && !(|b[51:0]);
        a_zero = !(|a[62:52]);
        b_zero = !(|b[62:52]);
        res    = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = FP64_QNAN;
        end else if (a_inf || b_inf) begin
            res = {s, 11'h7FF, 52'd0};
        end else if (a_zero || b_zero) begin
            res = {s, 63'd0};
        end else begin
            p = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
            e = int'(a[62:52]) + int'(b[62:52]) - 1023;
            if (p[105]) begin
                m  = p[105:53];
                g  = p[52];
                st = |p[51:0];
                e  = e + 1;
            end else begin
                m  = p[104:52];
                g  = p[51];
                st = |p[50:0];
            end
            rnd = g & (st | m[0]);
            mr  = {1'b0, m} + {53'd0, rnd};
            if (mr[53]) begin
                mr = mr >> 1;
                e  = e + 1;
            end
            if (e >= 2047)   res = {s, 11'h7FF, 52'd0};
            else if (e <= 0) res = {s, 63'd0};
            else             res = {s, e[10:0], mr[51:0]};
        end
        return res;
    endfunction

    function automatic fp64_t fp64_add(input fp64_t a, input fp64_t b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sticky, rnd;
        fp64_t       big, sml, res;
        logic [56:0] mb, ms, mr, mask;
        logic [53:0] mrnd;
        int          d, e, lz;
        a_nan  = (&a[62:52]) && (|a[51:0]);
        b_nan  = (&b[62:52]) && (|b[51:0]);
        a_inf  = (&a[62:52]) && !(|a[51:0]);
        b_inf  = (&b[62:52]) && !(|b[51:0]);
        a_zero = !(|a[62:52]);
        b_zero = !(|b[62:52]);
        res    = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[63] != b[63]))) begin
            res = FP64_QNAN;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (a_zero && b_zero) begin
            res = {a[63] & b[63], 63'd0};
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            if (a[62:0] >= b[62:0]) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            e  = int'(big[62:52]);
            d  = e - int'(sml[62:52]);
            // Bits [2:0] are guard/round/sticky; bit 56 catches the carry-out.
            mb = {2'b01, big[51:0], 3'b000};
            ms = {2'b01, sml[51:0], 3'b000};
            if (d > 56) begin
                ms = 57'd1;
            end else begin
                mask   = (57'd1 << d) - 57'd1;
                sticky = |(ms & mask);
                ms     = (ms >> d) | {56'd0, sticky};
            end
            if (big[63] == sml[63]) begin
                mr = mb + ms;
                if (mr[56]) begin
                    mr = {1'b0, mr[56:2], mr[1] | mr[0]};
                    e  = e + 1;
                end
            end else begin
                mr = mb - ms;
                lz = 56;
                for (int i = 0; i <= 55; i++) begin
                    if (mr[i]) lz = 55 - i;
                end
                if (mr != '0) begin
                    mr = mr << lz;
                    e  = e - lz;
                end
            end
            rnd  = mr[2] & (mr[1] | mr[0] | mr[3]);
            mrnd = {1'b0, mr[55:3]} + {53'd0, rnd};
            if (mrnd[53]) begin
                mrnd = mrnd >> 1;
                e    = e + 1;
            end
            if (mr == '0)      res = '0;
            else if (e >= 2047) res = {big[63], 11'h7FF, 52'd0};
            else if (e <= 0)    res = {big[63], 63'd0};
            else                res = {big[63], e[10:0], mrnd[51:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/acis_mac_lane.sv
// One FP64 lane: multiply-accumulate over a window of N beats, then delay the
// final sum so it appears OUT_LATENCY cycles after the window's last beat.
module acis_mac_lane
    import acis_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  fp64_t                   x_i,
    input  fp64_t                   w_i,
    input  logic [dwidth_RFadd-1:0] nent_i,
    output logic [dwidth_RFadd-1:0] idx_o,
    output fp64_t                   prod_o,
    output fp64_t                   w_o,
    output fp64_t                   x_o,
    output fp64_t                   acc_o,
    output fp64_t                   fin_o,
    output fp64_t                   res_o,
    output logic                    res_vld_o
);

    localparam int DLY = OUT_LATENCY - 1;

    logic [dwidth_RFadd-1:0] idx_q;
    fp64_t                   acc_q, prod_q, w_q, x_q, fin_q, res_q;
    fp64_t                   prod_d, acc_d;
    logic                    fin_vld_q, res_vld_q, last;
    logic [DLY-1:0]          dly_vld_q;
    fp64_t                   dly_q [DLY];

    assign prod_d = fp64_mul(x_i, w_i);
    assign acc_d  = fp64_add(acc_q, prod_d);
    // A >= compare keeps the window bounded even if N shrinks mid-window.
    assign last   = en_i && (idx_q >= nent_i - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            w_q       <= '0;
            x_q       <= '0;
            fin_q     <= '0;
            fin_vld_q <= 1'b0;
            dly_vld_q <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            if (en_i) begin
                prod_q <= prod_d;
                w_q    <= w_i;
                x_q    <= x_i;
                if (last) begin
                    idx_q <= '0;
                    acc_q <= '0;
                    fin_q <= acc_d;
                end else begin
                    idx_q <= idx_q + 1'b1;
                    acc_q <= acc_d;
                end
            end
            fin_vld_q <= last;
            dly_vld_q <= {dly_vld_q[DLY-2:0], fin_vld_q};
            res_vld_q <= dly_vld_q[DLY-1];
            if (dly_vld_q[DLY-1]) res_q <= dly_q[DLY-1];
        end
    end

    always_ff @(posedge clk_i) begin
        dly_q[0] <= fin_q;
        for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end

    assign idx_o     = idx_q;
    assign prod_o    = prod_q;
    assign w_o       = w_q;
    assign x_o       = x_q;
    assign acc_o     = acc_q;
    assign fin_o     = fin_q;
    assign res_o     = res_q;
    assign res_vld_o = res_vld_q;

endmodule

// File: rtl/acis_top.sv
// Streaming compute node: loader fills state/config/inbound tables, then a
// per-lane FP64 dot product runs against the inbound buffer.
module acis_top
    import acis_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [phit_size-1:0]    stream_in,
    input  logic [phit_size-1:0]    wr_data_ctrl_plane,
    input  logic                    start_loader,
    input  logic                    start_stream_in,
    input  logic [dwidth_RFadd-1:0] num_entry_config_table,
    input  logic [dwidth_RFadd-1:0] num_entry_inbound,
    input  logic [SIMD_degree-1:0]  t_stream_in_valid,
    output logic                    ready_stream_in,
    output logic [phit_size-1:0]    stream_out,
    output logic [SIMD_degree-1:0]  t_stream_out_valid,
    output logic [phit_size-1:0]    stream_out_PEa0,
    output logic [phit_size-1:0]    stream_out_PEa1,
    output logic [phit_size-1:0]    stream_out_PEb,
    output logic [phit_size-1:0]    stream_out_PEc0,
    output logic [phit_size-1:0]    stream_out_PEc1
);

    ld_state_e               ld_q, ld_d;
    ss_state_e               ss_q, ss_d;
    logic [dwidth_RFadd-1:0] k_q, k_d;
    logic [PE_W-1:0]         pe_q, pe_d;
    logic                    k_last_cfg, k_last_inb;

    logic [sz_state-1:0]     state_tbl_q [TBL_DEPTH];
    logic [sz_config-1:0]    cfg_tbl_q   [NUM_PE][TBL_DEPTH];
    fp64_t                   imm_tbl_q   [NUM_PE][TBL_DEPTH];
    logic [phit_size-1:0]    inb_tbl_q   [TBL_DEPTH];

    assign k_last_cfg = (k_q == num_entry_config_table - 1'b1);
    assign k_last_inb = (k_q == num_entry_inbound - 1'b1);

    always_comb begin
        ld_d = ld_q;
        k_d  = k_q;
        pe_d = pe_q;
        case (ld_q)
            LD_IDLE:  if (start_loader) ld_d = LD_WAIT1;
            LD_WAIT1: ld_d = LD_WAIT2;
            LD_WAIT2: begin
                ld_d = LD_STATE;
                k_d  = '0;
                pe_d = '0;
            end
            LD_STATE: begin
                if (k_last_cfg) begin
                    ld_d = LD_CFG;
                    k_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            LD_CFG: begin
                if (k_last_cfg) begin
                    k_d = '0;
                    if (pe_q == PE_W'(NUM_PE - 1)) ld_d = LD_INB;
                    else                           pe_d = pe_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            LD_INB: begin
                if (k_last_inb) ld_d = LD_DONE;
                else            k_d  = k_q + 1'b1;
            end
            LD_DONE:  ld_d = LD_DONE;
            default:  ld_d = LD_IDLE;
        endcase
    end

    always_comb begin
        ss_d = ss_q;
        case (ss_q)
            SS_WAIT_LOAD: if (ld_q == LD_DONE) ss_d = SS_HOLD;
            SS_HOLD:      if (!start_stream_in) ss_d = SS_READY;
            SS_READY:     ss_d = SS_READY;
            default:      ss_d = SS_WAIT_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q <= LD_IDLE;
            ss_q <= SS_WAIT_LOAD;
            k_q  <= '0;
            pe_q <= '0;
        end else begin
            ld_q <= ld_d;
            ss_q <= ss_d;
            k_q  <= k_d;
            pe_q <= pe_d;
        end
    end

    // Table storage carries no reset: contents are only meaningful after a load.
    always_ff @(posedge clk) begin
        if (ld_q == LD_STATE) state_tbl_q[k_q] <= wr_data_ctrl_plane[phit_size-1 -: sz_state];
        if (ld_q == LD_CFG) begin
            cfg_tbl_q[pe_q][k_q] <= wr_data_ctrl_plane[phit_size-1 -: sz_config];
            imm_tbl_q[pe_q][k_q] <= wr_data_ctrl_plane[dwidth_double-1:0];
        end
        if (ld_q == LD_INB) inb_tbl_q[k_q] <= wr_data_ctrl_plane;
    end

    assign ready_stream_in = (ss_q == SS_READY);

    for (genvar l = 0; l < SIMD_degree; l++) begin : g_lane
        logic [dwidth_RFadd-1:0] idx;
        fp64_t                   w;

        assign w = inb_tbl_q[idx][l*dwidth_double +: dwidth_double];

        acis_mac_lane u_lane (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (ready_stream_in && t_stream_in_valid[l]),
            .x_i       (stream_in[l*dwidth_double +: dwidth_double]),
            .w_i       (w),
            .nent_i    (num_entry_inbound),
            .idx_o     (idx),
            .prod_o    (stream_out_PEa0[l*dwidth_double +: dwidth_double]),
            .w_o       (stream_out_PEa1[l*dwidth_double +: dwidth_double]),
            .x_o       (stream_out_PEb[l*dwidth_double +: dwidth_double]),
            .acc_o     (stream_out_PEc0[l*dwidth_double +: dwidth_double]),
            .fin_o     (stream_out_PEc1[l*dwidth_double +: dwidth_double]),
            .res_o     (stream_out[l*dwidth_double +: dwidth_double]),
            .res_vld_o (t_stream_out_valid[l])
        );
    end

endmodule

// File: tb/tb_acis_top.sv
// Directed bench for acis_top: reset, load, stream gating, dot-product windows,
// per-lane valid gaps and reset during load.
module tb_acis_top;
    import acis_pkg::*;

    localparam logic [63:0] FH  = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F8  = 64'h4020_0000_0000_0000;
    localparam logic [63:0] F32 = 64'h4040_0000_0000_0000;
    localparam logic [63:0] F48 = 64'h4048_0000_0000_0000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [phit_size-1:0]    stream_in = '0;
    logic [phit_size-1:0]    wr_data_ctrl_plane = '0;
    logic                    start_loader = 1'b0;
    logic                    start_stream_in = 1'b1;
    logic [dwidth_RFadd-1:0] num_entry_config_table = 8'd2;
    logic [dwidth_RFadd-1:0] num_entry_inbound = 8'd16;
    logic [SIMD_degree-1:0]  t_stream_in_valid = '0;
    logic                    ready_stream_in;
    logic [phit_size-1:0]    stream_out;
    logic [SIMD_degree-1:0]  t_stream_out_valid;
    logic [phit_size-1:0]    stream_out_PEa0, stream_out_PEa1, stream_out_PEb;
    logic [phit_size-1:0]    stream_out_PEc0, stream_out_PEc1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bad_ready, bad_pulse, eo, e3;

    acis_top dut (
        .clk                    (clk),
        .rst                    (rst),
        .stream_in              (stream_in),
        .wr_data_ctrl_plane     (wr_data_ctrl_plane),
        .start_loader           (start_loader),
        .start_stream_in        (start_stream_in),
        .num_entry_config_table (num_entry_config_table),
        .num_entry_inbound      (num_entry_inbound),
        .t_stream_in_valid      (t_stream_in_valid),
        .ready_stream_in        (ready_stream_in),
        .stream_out             (stream_out),
        .t_stream_out_valid     (t_stream_out_valid),
        .stream_out_PEa0        (stream_out_PEa0),
        .stream_out_PEa1        (stream_out_PEa1),
        .stream_out_PEb         (stream_out_PEb),
        .stream_out_PEc0        (stream_out_PEc0),
        .stream_out_PEc1        (stream_out_PEc1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [phit_size-1:0] obs,
                         input logic [phit_size-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [phit_size-1:0] cfg_phit(input int pe, input int k);
        logic [35:0] c;
        logic [63:0] m;
        c = 36'hC_0000_0000 + 36'(pe * 16 + k);
        m = 64'h1111_0000_0000_0000 + 64'(pe * 256 + k);
        return {c, 412'd0, m};
    endfunction

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_stream_out", stream_out, '0);
        check("rst_out_valid", phit_size'(t_stream_out_valid), '0);
        check("rst_ready", phit_size'(ready_stream_in), '0);
        check("rst_taps", stream_out_PEa0 | stream_out_PEa1 | stream_out_PEb | stream_out_PEc0 | stream_out_PEc1, '0);
        tick();
        tick();
        rst = 1'b0;

        // Idle before load: beats presented, nothing accepted
        stream_in = {8{F2}};
        t_stream_in_valid = 8'hFF;
        bad_ready = 0;
        bad_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready_stream_in) bad_ready++;
            if (|t_stream_out_valid) bad_pulse++;
        end
        check("idle_ready_low", phit_size'(bad_ready), '0);
        check("idle_no_pulse", phit_size'(bad_pulse), '0);

        // Load sequence
        start_loader = 1'b1;
        tick();
        start_loader = 1'b0;
        check("ld_wait1", phit_size'(dut.ld_q), phit_size'(LD_WAIT1));
        tick();
        tick();
        wr_data_ctrl_plane = {48'h8000_0000_0010, 464'd0};
        tick();
        wr_data_ctrl_plane = {48'h800A_0000_0000, 464'd0};
        tick();
        for (int pe = 0; pe < NUM_PE; pe++) begin
            for (int k = 0; k < 2; k++) begin
                wr_data_ctrl_plane = cfg_phit(pe, k);
                tick();
            end
        end
        wr_data_ctrl_plane = {8{F1}};
        for (int k = 0; k < 16; k++) tick();
        check("state_tbl0", phit_size'(dut.state_tbl_q[0]), phit_size'(48'h8000_0000_0010));
        check("state_tbl1", phit_size'(dut.state_tbl_q[1]), phit_size'(48'h800A_0000_0000));
        check("cfg_tbl_0_0", phit_size'(dut.cfg_tbl_q[0][0]), phit_size'(36'hC_0000_0000));
        check("cfg_tbl_5_1", phit_size'(dut.cfg_tbl_q[5][1]), phit_size'(36'hC_0000_0051));
        check("imm_tbl_3_0", phit_size'(dut.imm_tbl_q[3][0]), phit_size'(64'h1111_0000_0000_0300));
        check("inb_tbl15", dut.inb_tbl_q[15], {8{F1}});
        check("ld_done", phit_size'(dut.ld_q), phit_size'(LD_DONE));

        // Hold with start_stream_in high; beats still dropped
        bad_ready = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ready_stream_in) bad_ready++;
        end
        check("hold_ready_low", phit_size'(bad_ready), '0);
        t_stream_in_valid = 8'h00;
        start_stream_in = 1'b0;
        check("ready_before_release", phit_size'(ready_stream_in), '0);
        tick();
        check("ready_after_release", phit_size'(ready_stream_in), 1);

        // Window 1: 16 beats of 2.0 against 1.0
        stream_in = {8{F2}};
        t_stream_in_valid = 8'hFF;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 4) check("acc_after4", stream_out_PEc0, {8{F8}});
        end
        t_stream_in_valid = 8'h00;
        check("tap_prod", stream_out_PEa0, {8{F2}});
        check("tap_opnd", stream_out_PEa1, {8{F1}});
        check("tap_beat", stream_out_PEb, {8{F2}});
        check("tap_final", stream_out_PEc1, {8{F32}});
        bad_pulse = 0;
        for (int i = 1; i <= 78; i++) begin
            tick();
            if (|t_stream_out_valid) bad_pulse++;
        end
        check("w1_no_early", phit_size'(bad_pulse), '0);
        tick();
        check("w1_valid", phit_size'(t_stream_out_valid), phit_size'(8'hFF));
        check("w1_data", stream_out, {8{F32}});
        tick();
        check("w1_pulse_end", phit_size'(t_stream_out_valid), '0);
        check("w1_data_hold", stream_out, {8{F32}});

        // Window 2: lane 3 valid every other cycle
        stream_in = {FH, FH, FH, FH, F3, FH, FH, FH};
        eo = 0;
        e3 = 0;
        for (int i = 0; i <= 30; i++) begin
            t_stream_in_valid = ((i < 16) ? 8'hF7 : 8'h00) | ((i % 2 == 0) ? 8'h08 : 8'h00);
            tick();
            if (i == 15) eo = cyc;
            if (i == 30) e3 = cyc;
        end
        t_stream_in_valid = 8'h00;
        bad_pulse = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (cyc == eo + 79) begin
                check("w2_other_valid", phit_size'(t_stream_out_valid), phit_size'(8'hF7));
                check("w2_other_data", stream_out, {F8, F8, F8, F8, F32, F8, F8, F8});
            end else if (cyc == e3 + 79) begin
                check("w2_lane3_valid", phit_size'(t_stream_out_valid), phit_size'(8'h08));
                check("w2_lane3_data", stream_out, {F8, F8, F8, F8, F48, F8, F8, F8});
            end else if (|t_stream_out_valid) begin
                bad_pulse++;
            end
        end
        check("w2_no_stray", phit_size'(bad_pulse), '0);

        // Asynchronous reset clears outputs immediately
        rst = 1'b1;
        #2;
        check("rst2_stream_out", stream_out, '0);
        check("rst2_ready", phit_size'(ready_stream_in), '0);
        check("rst2_final_tap", stream_out_PEc1, '0);
        tick();
        rst = 1'b0;

        // Reset during LD_INB aborts the load
        start_loader = 1'b1;
        tick();
        start_loader = 1'b0;
        wr_data_ctrl_plane = {8{F1}};
        for (int i = 0; i < 19; i++) tick();
        check("mid_ld_inb", phit_size'(dut.ld_q), phit_size'(LD_INB));
        rst = 1'b1;
        #2;
        check("abort_ready", phit_size'(ready_stream_in), '0);
        check("abort_out", stream_out | phit_size'(t_stream_out_valid), '0);
        check("abort_ld_idle", phit_size'(dut.ld_q), phit_size'(LD_IDLE));
        tick();
        rst = 1'b0;
        t_stream_in_valid = 8'hFF;
        bad_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready_stream_in) bad_ready++;
        end
        check("abort_no_ready", phit_size'(bad_ready), '0);

        // Full reload then release
        t_stream_in_valid = 8'h00;
        start_loader = 1'b1;
        tick();
        start_loader = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        check("reload_done", phit_size'(dut.ld_q), phit_size'(LD_DONE));
        check("reload_ready", phit_size'(ready_stream_in), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
